issue_fifo_inorder: RTL and testbench

In-order issue buffer between rename/dispatch and the execute-stage pipeline register. It holds up to DEPTH renamed instructions, tracks source-operand readiness per entry from the busy table and writeback wakeups, and presents the oldest entry downstream only once both sources are ready. It uses a valid/ready handshake on both sides, and a flush clears it.

---
 rtl/issue_fifo_inorder.sv | 153 +++++++++++++++
 tb/tb_issue_fifo_inorder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_fifo_inorder.sv
// In-order issue buffer: holds renamed instructions until both source operands
// are ready, then hands the oldest one to the execute pipeline register.
module issue_fifo_inorder #(
   parameter int DEPTH     = 4,
   parameter int PREG_W    = 6,
   parameter int PAYLOAD_W = 160
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    flush_valid,
   input  logic                    enq_valid,
   output logic                    enq_ready,
   input  logic [PAYLOAD_W-1:0]    enq_payload,
   input  logic [PREG_W-1:0]       enq_prs1,
   input  logic [PREG_W-1:0]       enq_prs2,
   input  logic [PREG_W-1:0]       enq_prd,
   input  logic                    enq_src1_is_reg,
   input  logic                    enq_src2_is_reg,
   input  logic [2**PREG_W-1:0]    busy_vec,
   input  logic                    wb_valid,
   input  logic [PREG_W-1:0]       wb_prd,
   output logic                    deq_valid,
   input  logic                    deq_ready,
   output logic [PAYLOAD_W-1:0]    deq_payload,
   output logic [PREG_W-1:0]       deq_prs1,
   output logic [PREG_W-1:0]       deq_prs2,
   output logic [PREG_W-1:0]       deq_prd,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   // A source is ready at enqueue if it is not a register, is the hardwired
   // zero register, is not busy, or is being written back this very cycle.
   function automatic logic src_ready(input logic               is_reg,
                                      input logic [PREG_W-1:0]  prs,
                                      input logic [2**PREG_W-1:0] busy,
                                      input logic               wbv,
                                      input logic [PREG_W-1:0]  wbp);
      return !is_reg || (prs == '0) || !busy[prs] || (wbv && (wbp == prs));
   endfunction

   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [PAYLOAD_W-1:0] payload_q [DEPTH];
   logic [PAYLOAD_W-1:0] payload_d [DEPTH];
   logic [PREG_W-1:0]    prs1_q [DEPTH];
   logic [PREG_W-1:0]    prs1_d [DEPTH];
   logic [PREG_W-1:0]    prs2_q [DEPTH];
   logic [PREG_W-1:0]    prs2_d [DEPTH];
   logic [PREG_W-1:0]    prd_q  [DEPTH];
   logic [PREG_W-1:0]    prd_d  [DEPTH];
   logic [DEPTH-1:0]     rdy1_q, rdy1_d;
   logic [DEPTH-1:0]     rdy2_q, rdy2_d;

   logic [IDX_W-1:0]     head_idx;
   logic [IDX_W-1:0]     tail_idx;
   logic                 empty;
   logic                 full;
   logic                 enq_fire;
   logic                 deq_fire;
   logic [DEPTH-1:0]     occupied;

   assign head_idx  = head_q[IDX_W-1:0];
   assign tail_idx  = tail_q[IDX_W-1:0];
   assign empty     = (head_q == tail_q);
   assign full      = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
   assign count     = tail_q - head_q;

   // Readiness and head fields come from registered state only; flush gates both sides.
   assign enq_ready = !full && !flush_valid;
   assign deq_valid = !empty && rdy1_q[head_idx] && rdy2_q[head_idx] && !flush_valid;
   assign enq_fire  = enq_valid && enq_ready;
   assign deq_fire  = deq_valid && deq_ready;

   assign deq_payload = payload_q[head_idx];
   assign deq_prs1    = prs1_q[head_idx];
   assign deq_prs2    = prs2_q[head_idx];
   assign deq_prd     = prd_q[head_idx];

   // Mark slots that currently hold a live entry (distance from head below count).
   always_comb begin
      occupied = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupied[i] = ({1'b0, IDX_W'(i) - head_idx} < count);
      end
   end

   // Next state: flush wins; otherwise wakeup live entries, write tail, advance head.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      payload_d = payload_q;
      prs1_d    = prs1_q;
      prs2_d    = prs2_q;
      prd_d     = prd_q;
      rdy1_d    = rdy1_q;
      rdy2_d    = rdy2_q;
      if (flush_valid) begin
         head_d = '0;
         tail_d = '0;
         rdy1_d = '0;
         rdy2_d = '0;
      end else begin
         if (wb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (occupied[i] && (prs1_q[i] == wb_prd)) rdy1_d[i] = 1'b1;
               if (occupied[i] && (prs2_q[i] == wb_prd)) rdy2_d[i] = 1'b1;
            end
         end
         // The tail slot is never live when enqueue fires, so this cannot clobber a wakeup.
         if (enq_fire) begin
            payload_d[tail_idx] = enq_payload;
            prs1_d[tail_idx]    = enq_prs1;
            prs2_d[tail_idx]    = enq_prs2;
            prd_d[tail_idx]     = enq_prd;
            rdy1_d[tail_idx]    = src_ready(enq_src1_is_reg, enq_prs1, busy_vec, wb_valid, wb_prd);
            rdy2_d[tail_idx]    = src_ready(enq_src2_is_reg, enq_prs2, busy_vec, wb_valid, wb_prd);
            tail_d              = tail_q + PTR_W'(1);
         end
         if (deq_fire) begin
            head_d = head_q + PTR_W'(1);
         end
      end
   end

   // State registers with asynchronous clear of pointers and every entry field.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q <= '0;
         tail_q <= '0;
         rdy1_q <= '0;
         rdy2_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            payload_q[i] <= '0;
            prs1_q[i]    <= '0;
            prs2_q[i]    <= '0;
            prd_q[i]     <= '0;
         end
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         rdy1_q    <= rdy1_d;
         rdy2_q    <= rdy2_d;
         payload_q <= payload_d;
         prs1_q    <= prs1_d;
         prs2_q    <= prs2_d;
         prd_q     <= prd_d;
      end
   end

endmodule

// File: tb/tb_issue_fifo_inorder.sv
// Table-driven bench for issue_fifo_inorder: one row per clock cycle, giving the
// inputs for that cycle and the outputs expected just after they are applied.
module tb_issue_fifo_inorder;

   localparam int DEPTH     = 4;
   localparam int PREG_W    = 6;
   localparam int PAYLOAD_W = 160;

   logic                   clock = 1'b0;
   logic                   reset_n;
   logic                   flush_valid;
   logic                   enq_valid;
   logic                   enq_ready;
   logic [PAYLOAD_W-1:0]   enq_payload;
   logic [PREG_W-1:0]      enq_prs1, enq_prs2, enq_prd;
   logic                   enq_src1_is_reg, enq_src2_is_reg;
   logic [2**PREG_W-1:0]   busy_vec;
   logic                   wb_valid;
   logic [PREG_W-1:0]      wb_prd;
   logic                   deq_valid;
   logic                   deq_ready;
   logic [PAYLOAD_W-1:0]   deq_payload;
   logic [PREG_W-1:0]      deq_prs1, deq_prs2, deq_prd;
   logic [$clog2(DEPTH):0] count;

   issue_fifo_inorder #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
      .clock(clock), .reset_n(reset_n), .flush_valid(flush_valid),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
      .enq_prs1(enq_prs1), .enq_prs2(enq_prs2), .enq_prd(enq_prd),
      .enq_src1_is_reg(enq_src1_is_reg), .enq_src2_is_reg(enq_src2_is_reg),
      .busy_vec(busy_vec), .wb_valid(wb_valid), .wb_prd(wb_prd),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_payload(deq_payload),
      .deq_prs1(deq_prs1), .deq_prs2(deq_prs2), .deq_prd(deq_prd), .count(count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        en;
      int          id;
      logic        s1r;
      logic [5:0]  p1;
      logic        s2r;
      logic [5:0]  p2;
      logic [63:0] busy;
      logic        wbv;
      logic [5:0]  wbp;
      logic        dr;
      logic        fl;
      logic        e_dv;
      logic        e_er;
      int          e_cnt;
      logic        chk;
      int          e_id;
   } vec_t;

   vec_t vq[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic logic [PAYLOAD_W-1:0] mk(input int id);
      logic [31:0] u;
      u = id;
      return {u, ~u, u ^ 32'hA5A5_5A5A, ~u, u};
   endfunction

   function automatic logic [63:0] bit_at(input int n);
      logic [63:0] b;
      b = '0;
      b[n] = 1'b1;
      return b;
   endfunction

   task automatic add(input logic en, input int id, input logic s1r, input logic [5:0] p1,
                      input logic s2r, input logic [5:0] p2, input logic [63:0] busy,
                      input logic wbv, input logic [5:0] wbp, input logic dr, input logic fl,
                      input logic e_dv, input logic e_er, input int e_cnt,
                      input logic chk, input int e_id);
      vec_t v;
      v.en = en; v.id = id; v.s1r = s1r; v.p1 = p1; v.s2r = s2r; v.p2 = p2;
      v.busy = busy; v.wbv = wbv; v.wbp = wbp; v.dr = dr; v.fl = fl;
      v.e_dv = e_dv; v.e_er = e_er; v.e_cnt = e_cnt; v.chk = chk; v.e_id = e_id;
      vq.push_back(v);
   endtask

   // Enqueue an entry whose sources are both immediates.
   task automatic en_rdy(input int id, input logic dr, input logic e_dv, input logic e_er,
                         input int e_cnt, input logic chk, input int e_id);
      add(1'b1, id, 1'b0, 6'd0, 1'b0, 6'd0, '0, 1'b0, 6'd0, dr, 1'b0, e_dv, e_er, e_cnt, chk, e_id);
   endtask

   task automatic idle(input logic dr, input logic e_dv, input logic e_er,
                       input int e_cnt, input logic chk, input int e_id);
      add(1'b0, 0, 1'b0, 6'd0, 1'b0, 6'd0, '0, 1'b0, 6'd0, dr, 1'b0, e_dv, e_er, e_cnt, chk, e_id);
   endtask

   task automatic check(input string name, input int row,
                        input logic [PAYLOAD_W-1:0] act, input logic [PAYLOAD_W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (row %0d): got %0h expected %0h", name, row, act, exp);
   endtask

   task automatic drive_quiet();
      flush_valid = 1'b0; enq_valid = 1'b0; enq_payload = '0;
      enq_prs1 = '0; enq_prs2 = '0; enq_prd = '0;
      enq_src1_is_reg = 1'b0; enq_src2_is_reg = 1'b0;
      busy_vec = '0; wb_valid = 1'b0; wb_prd = '0; deq_ready = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      drive_quiet();

      // ---- vector table ----
      // single ready entry: visible one cycle after enqueue, count 0->1->0
      en_rdy(1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
      idle(1'b1, 1'b1, 1'b1, 1, 1'b1, 1);
      idle(1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
      // busy src1=5, woken by writeback; deq_valid appears the cycle after
      add(1'b1, 2, 1'b1, 6'd5, 1'b0, 6'd0, bit_at(5), 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
      add(1'b0, 0, 1'b0, 6'd0, 1'b0, 6'd0, bit_at(5), 1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 2);
      idle(1'b1, 1'b1, 1'b1, 1, 1'b1, 2);
      idle(1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
      // blocked head on 7; younger ready entry must wait its turn
      add(1'b1, 3, 1'b1, 6'd7, 1'b0, 6'd0, bit_at(7), 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
      add(1'b1, 4, 1'b0, 6'd7, 1'b0, 6'd7, bit_at(7), 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 3);
      add(1'b0, 0, 1'b0, 6'd0, 1'b0, 6'd0, bit_at(7), 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 3);
      add(1'b0, 0, 1'b0, 6'd0, 1'b0, 6'd0, bit_at(7), 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 3);
      idle(1'b1, 1'b1, 1'b1, 2, 1'b1, 3);
      idle(1'b1, 1'b1, 1'b1, 1, 1'b1, 4);
      idle(1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
      // fill to 4 with deq stalled, then enq+deq while full: only the dequeue happens
      en_rdy(5, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
      en_rdy(6, 1'b0, 1'b1, 1'b1, 1, 1'b1, 5);
      en_rdy(7, 1'b0, 1'b1, 1'b1, 2, 1'b1, 5);
      en_rdy(8, 1'b0, 1'b1, 1'b1, 3, 1'b1, 5);
      en_rdy(9, 1'b1, 1'b1, 1'b0, 4, 1'b1, 5);
      idle(1'b0, 1'b1, 1'b1, 3, 1'b1, 6);
      idle(1'b1, 1'b1, 1'b1, 3, 1'b1, 6);
      idle(1'b1, 1'b1, 1'b1, 2, 1'b1, 7);
      idle(1'b1, 1'b1, 1'b1, 1, 1'b1, 8);
      // ten back-to-back entries streaming through, pointers wrap
      for (int k = 0; k < 10; k++) begin
         en_rdy(10 + k, 1'b1, (k > 0), 1'b1, (k > 0) ? 1 : 0, (k > 0), 9 + k);
      end
      idle(1'b1, 1'b1, 1'b1, 1, 1'b1, 19);
      idle(1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
      // flush with three held entries, concurrent enq and wakeup
      en_rdy(20, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
      en_rdy(21, 1'b0, 1'b1, 1'b1, 1, 1'b1, 20);
      en_rdy(22, 1'b0, 1'b1, 1'b1, 2, 1'b1, 20);
      add(1'b1, 23, 1'b0, 6'd0, 1'b0, 6'd0, bit_at(9), 1'b1, 6'd9, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1, 20);
      idle(1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
      en_rdy(24, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
      idle(1'b1, 1'b1, 1'b1, 1, 1'b1, 24);
      idle(1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
      // busy source woken in the enqueue cycle itself
      add(1'b1, 25, 1'b1, 6'd11, 1'b0, 6'd0, bit_at(11), 1'b1, 6'd11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
      idle(1'b1, 1'b1, 1'b1, 1, 1'b1, 25);
      // register 0 is always ready even if marked busy
      add(1'b1, 26, 1'b0, 6'd0, 1'b1, 6'd0, bit_at(0), 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
      idle(1'b1, 1'b1, 1'b1, 1, 1'b1, 26);
      // src2 pending; an unrelated writeback must not wake it
      add(1'b1, 27, 1'b1, 6'd13, 1'b1, 6'd12, bit_at(12), 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
      add(1'b0, 0, 1'b0, 6'd0, 1'b0, 6'd0, bit_at(12), 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 27);
      add(1'b0, 0, 1'b0, 6'd0, 1'b0, 6'd0, bit_at(12), 1'b1, 6'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 27);
      idle(1'b1, 1'b1, 1'b1, 1, 1'b1, 27);
      idle(1'b1, 1'b0, 1'b1, 0, 1'b0, 0);

      // ---- reset state ----
      #12;
      check("reset deq_valid", -1, deq_valid, 1'b0);
      check("reset enq_ready", -1, enq_ready, 1'b1);
      check("reset count", -1, count, 0);
      check("reset deq_payload", -1, deq_payload, '0);
      #1 reset_n = 1'b1;

      // ---- apply table ----
      foreach (vq[r]) begin
         @(posedge clock); #1;
         enq_valid       = vq[r].en;
         enq_payload     = mk(vq[r].id);
         enq_prd         = 6'(vq[r].id);
         enq_src1_is_reg = vq[r].s1r;
         enq_prs1        = vq[r].p1;
         enq_src2_is_reg = vq[r].s2r;
         enq_prs2        = vq[r].p2;
         busy_vec        = vq[r].busy;
         wb_valid        = vq[r].wbv;
         wb_prd          = vq[r].wbp;
         deq_ready       = vq[r].dr;
         flush_valid     = vq[r].fl;
         #1;
         check("deq_valid", r, deq_valid, vq[r].e_dv);
         check("enq_ready", r, enq_ready, vq[r].e_er);
         check("count", r, count, vq[r].e_cnt);
         if (vq[r].chk) begin
            check("deq_payload", r, deq_payload, mk(vq[r].e_id));
            check("deq_prd", r, deq_prd, 6'(vq[r].e_id));
         end
      end

      // ---- asynchronous reset in the middle of operation ----
      @(posedge clock); #1;
      drive_quiet();
      enq_valid = 1'b1; enq_payload = mk(30); enq_prd = 6'd30;
      @(posedge clock); #1;
      drive_quiet();
      #1;
      check("pre-reset count", 100, count, 1);
      check("pre-reset deq_valid", 100, deq_valid, 1'b1);
      reset_n = 1'b0;
      #1;
      check("mid-reset count", 101, count, 0);
      check("mid-reset deq_valid", 101, deq_valid, 1'b0);
      check("mid-reset enq_ready", 101, enq_ready, 1'b1);
      check("mid-reset deq_payload", 101, deq_payload, '0);
      check("mid-reset deq_prd", 101, deq_prd, '0);
      #1 reset_n = 1'b1;
      @(posedge clock); #1;
      enq_valid = 1'b1; enq_payload = mk(31); enq_prd = 6'd31;
      @(posedge clock); #1;
      drive_quiet();
      #1;
      check("post-reset count", 102, count, 1);
      check("post-reset deq_payload", 102, deq_payload, mk(31));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
